// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter sequencing driver.
// The phase-skip helper is shared by the IDLE and CLR exits so both follow one rule.
package counter_pkg;

   localparam int CNT_W_DEF    = 16;
   localparam int SLT_DIV_DEF  = 4;
   localparam int SLT_LOG2_DEF = $clog2(SLT_DIV_DEF);
   localparam int T1_W_DEF     = CNT_W_DEF - SLT_LOG2_DEF;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      RUN0 = 3'd2,
      RUN1 = 3'd3,
      DONE = 3'd4
   } state_t;

   // First phase with work to do, skipping phases whose target is zero.
   function automatic state_t first_phase(input logic t0_nz, input logic t1_nz);
      if (t0_nz)      return RUN0;
      else if (t1_nz) return RUN1;
      else            return DONE;
   endfunction

endpackage

// File: rtl/cycle_downcounter.sv
// Loadable down counter with a zero flag; holds at zero until reloaded.
module cycle_downcounter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/counter_driver.sv
// Generates the Slt/En/Reset control stream for the dual-output counter from a latched request.
//
// state | meaning
// IDLE  | waiting for Start, all outputs low
// CLR   | one-cycle counter reset (CntReset=1)
// RUN0  | t0 enabled cycles with Slt=0
// RUN1  | SLT_DIV*t1 enabled cycles with Slt=1
// DONE  | one-cycle Done pulse, still Busy
module counter_driver
   import counter_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int SLT_DIV = SLT_DIV_DEF,
   parameter int T1_W    = CNT_W - $clog2(SLT_DIV)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Clear,
   input  logic             Abort,
   input  logic [CNT_W-1:0] Target0,
   input  logic [T1_W-1:0]  Target1,
   output logic             CntReset,
   output logic             Slt,
   output logic             En,
   output logic             Busy,
   output logic             Done
);

   localparam int SLT_LOG2 = $clog2(SLT_DIV);

   state_t           state, state_nx;
   logic [CNT_W-1:0] t0_q;
   logic [T1_W-1:0]  t1_q;
   logic [CNT_W-1:0] t0_src;
   logic [T1_W-1:0]  t1_src;
   logic [CNT_W-1:0] run1_len;
   logic             cnt_load;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;

   cycle_downcounter #(.W(CNT_W)) u_cnt (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nx = state;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      cnt_val  = '0;
      // In IDLE the targets are being latched on this same edge, so use them directly.
      t0_src   = (state == IDLE) ? Target0 : t0_q;
      t1_src   = (state == IDLE) ? Target1 : t1_q;
      run1_len = CNT_W'(t1_src) << SLT_LOG2;

      case (state)
         IDLE: begin
            if (Start)
               state_nx = Clear ? CLR : first_phase(t0_src != '0, t1_src != '0);
         end
         CLR: begin
            if (Abort) state_nx = IDLE;
            else       state_nx = first_phase(t0_src != '0, t1_src != '0);
         end
         RUN0: begin
            cnt_en = 1'b1;
            if (Abort)         state_nx = IDLE;
            else if (cnt_zero) state_nx = (t1_src != '0) ? RUN1 : DONE;
         end
         RUN1: begin
            cnt_en = 1'b1;
            if (Abort)         state_nx = IDLE;
            else if (cnt_zero) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Counter reloads on phase entry so it reads 0 on the last cycle of the phase.
      if ((state_nx == RUN0) && (state != RUN0)) begin
         cnt_load = 1'b1;
         cnt_val  = t0_src - CNT_W'(1);
      end else if ((state_nx == RUN1) && (state != RUN1)) begin
         cnt_load = 1'b1;
         cnt_val  = run1_len - CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         t0_q     <= '0;
         t1_q     <= '0;
         CntReset <= 1'b0;
         Slt      <= 1'b0;
         En       <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == IDLE) && Start) begin
            t0_q <= Target0;
            t1_q <= Target1;
         end
         // Outputs are decoded from the next state so they align with the registered state.
         CntReset <= (state_nx == CLR);
         Slt      <= (state_nx == RUN1);
         En       <= (state_nx == RUN0) || (state_nx == RUN1);
         Busy     <= (state_nx != IDLE);
         Done     <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_counter_driver.sv
// Self-checking bench for counter_driver: per-cycle comparison against a queue-based model plus literal pins.
module tb_counter_driver;
   import counter_pkg::*;

   logic                 Clk = 1'b0;
   logic                 Reset = 1'b1;
   logic                 Start = 1'b0;
   logic                 Clear = 1'b0;
   logic                 Abort = 1'b0;
   logic [CNT_W_DEF-1:0] Target0 = '0;
   logic [T1_W_DEF-1:0]  Target1 = '0;
   logic CntReset, Slt, En, Busy, Done;

   counter_driver dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Clear(Clear), .Abort(Abort),
      .Target0(Target0), .Target1(Target1),
      .CntReset(CntReset), .Slt(Slt), .En(En), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // Output vector: {CntReset, Slt, En, Busy, Done}
   typedef logic [4:0] vec_t;
   localparam vec_t V_CLR  = 5'b10010;
   localparam vec_t V_RUN0 = 5'b00110;
   localparam vec_t V_RUN1 = 5'b01110;
   localparam vec_t V_DONE = 5'b00011;

   vec_t q[$];
   vec_t cur = '0;
   bit   chk_en = 1'b0;

   // Model: an accepted request expands into the full list of per-cycle output vectors.
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q.delete();
         cur = '0;
      end else if (!cur[1]) begin
         if (Start) begin
            q.delete();
            if (Clear) q.push_back(V_CLR);
            for (int i = 0; i < int'(Target0); i++) q.push_back(V_RUN0);
            for (int i = 0; i < SLT_DIV_DEF * int'(Target1); i++) q.push_back(V_RUN1);
            q.push_back(V_DONE);
            cur = q.pop_front();
         end else begin
            cur = '0;
         end
      end else if (Abort && !cur[0]) begin
         q.delete();
         cur = '0;
      end else begin
         cur = (q.size() != 0) ? q.pop_front() : vec_t'(0);
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         total++;
         if ({CntReset, Slt, En, Busy, Done} !== cur) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t dut=%b model=%b", $time,
                     {CntReset, Slt, En, Busy, Done}, cur);
         end
      end
   end

   // Event counters over a window, sampled just after each rising edge.
   int idx, n_busy, n_en0, n_en1, n_cr, n_done, first_cr, first_en, first_done;
   always @(posedge Clk) begin
      #1;
      idx++;
      if (Busy) n_busy++;
      if (En && !Slt) n_en0++;
      if (En && Slt) n_en1++;
      if (CntReset) begin n_cr++; if (first_cr < 0) first_cr = idx; end
      if (En && first_en < 0) first_en = idx;
      if (Done) begin n_done++; if (first_done < 0) first_done = idx; end
   end

   task automatic clr_mon();
      idx = 0; n_busy = 0; n_en0 = 0; n_en1 = 0; n_cr = 0; n_done = 0;
      first_cr = -1; first_en = -1; first_done = -1;
   endtask

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic start_req(input bit c, input int t0, input int t1);
      @(negedge Clk);
      Start = 1'b1; Clear = c;
      Target0 = CNT_W_DEF'(t0); Target1 = T1_W_DEF'(t1);
      clr_mon();
      @(negedge Clk);
      Start = 1'b0; Clear = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   initial begin
      repeat (3) @(posedge Clk);
      chk_en = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("reset_outputs", int'({CntReset, Slt, En, Busy, Done}), 0);

      // Test 1: clear + (5,2)
      start_req(1'b1, 5, 2);
      wait_cycles(18);
      check("t1_busy", n_busy, 15);
      check("t1_en0", n_en0, 5);
      check("t1_en1", n_en1, 8);
      check("t1_cr", n_cr, 1);
      check("t1_done", n_done, 1);
      check("t1_first_cr", first_cr, 1);
      check("t1_first_en", first_en, 2);

      // Test 2: (0,3) without clear
      start_req(1'b0, 0, 3);
      wait_cycles(15);
      check("t2_en0", n_en0, 0);
      check("t2_en1", n_en1, 12);
      check("t2_first_en", first_en, 1);
      check("t2_done", n_done, 1);

      // Test 3: (0,0)
      start_req(1'b0, 0, 0);
      wait_cycles(3);
      check("t3_en", n_en0 + n_en1, 0);
      check("t3_done", n_done, 1);
      check("t3_first_done", first_done, 1);
      check("t3_busy", n_busy, 1);

      // Test 4: abort on the 4th RUN0 cycle, then a normal run
      start_req(1'b0, 10, 1);
      wait_cycles(3);
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      check("t4_busy_after_abort", int'(Busy), 0);
      check("t4_en_after_abort", int'(En), 0);
      wait_cycles(4);
      check("t4_en0", n_en0, 4);
      check("t4_no_done", n_done, 0);
      wait_cycles(1);
      start_req(1'b0, 2, 0);
      wait_cycles(5);
      check("t4b_en0", n_en0, 2);
      check("t4b_done", n_done, 1);

      // Test 5: Start during RUN1 is ignored
      start_req(1'b0, 3, 1);
      wait_cycles(4);
      Start = 1'b1; Target0 = 16'd99;
      @(negedge Clk);
      Start = 1'b0;
      wait_cycles(6);
      check("t5_en_total", n_en0 + n_en1, 7);
      check("t5_done", n_done, 1);

      // Test 6: asynchronous reset mid-RUN1
      start_req(1'b0, 2, 3);
      wait_cycles(3);
      check("t6_in_run1", int'(En && Slt), 1);
      #2 Reset = 1'b1;
      #1 check("t6_async_reset", int'({CntReset, Slt, En, Busy, Done}), 0);
      @(negedge Clk);
      Reset = 1'b0;
      start_req(1'b0, 1, 0);
      wait_cycles(3);
      check("t6_restart_done", n_done, 1);
      check("t6_restart_en0", n_en0, 1);

      // Randomized runs with stray Starts and occasional Aborts
      for (int r = 0; r < 40; r++) begin
         int t0, t1, len;
         t0 = $urandom_range(0, 6);
         t1 = $urandom_range(0, 3);
         len = t0 + 4 * t1 + 3;
         start_req(1'($urandom_range(0, 1)), t0, t1);
         for (int k = 0; k < len; k++) begin
            @(negedge Clk);
            Abort = ($urandom_range(0, 19) == 0);
            Start = ($urandom_range(0, 9) == 0);
            Clear = 1'($urandom_range(0, 1));
            Target0 = CNT_W_DEF'($urandom_range(0, 6));
            Target1 = T1_W_DEF'($urandom_range(0, 3));
         end
         @(negedge Clk);
         Abort = 1'b0; Start = 1'b0; Clear = 1'b0;
         wait_cycles(40);
      end

      wait_cycles(2);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
